// File: rtl/l1_data_cache.sv
// l1_data_cache: direct-mapped, write-back, write-allocate L1 data cache.
// Serves one single-word core load/store at a time. On a miss it first writes
// back a dirty victim line, then fetches the whole line through the
// line-granular memory request/response handshake.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   cpu_req_*                     core request (valid/ready, store, addr, wdata, wstrb)
//   cpu_resp_valid/_data          one-cycle response (load data or post-merge store word)
//   mem_valid/_store/_addr/_wdata line request to the bus (writeback or fill)
//   mem_ready                     bus accepts the line request
//   mem_resp_valid/_data          fill line from the bus
//   mem_rready                    cache consumes the fill
//
// state       | meaning
// IDLE        | waiting for a core request
// LOOKUP      | tag compare; hit served here, miss picks writeback or fill
// WRITEBACK   | dirty victim line offered to the bus
// FILL_REQ    | line fill request offered to the bus
// FILL_WAIT   | waiting for the fill line, installed on arrival
// RESPOND     | response pulse to the core
module l1_data_cache #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int CHUNKS_LOG = 4,
    parameter int SETS_LOG   = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cpu_req_valid,
    output logic                                cpu_req_ready,
    input  logic                                cpu_req_store,
    input  logic [ADDR_WIDTH-1:0]               cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]               cpu_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]             cpu_req_wstrb,
    output logic                                cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]               cpu_resp_data,
    output logic                                mem_valid,
    output logic                                mem_store,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [(DATA_WIDTH<<CHUNKS_LOG)-1:0] mem_wdata,
    input  logic                                mem_ready,
    input  logic                                mem_resp_valid,
    input  logic [(DATA_WIDTH<<CHUNKS_LOG)-1:0] mem_resp_data,
    output logic                                mem_rready
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int OFF_W   = $clog2(STRB_W);
    localparam int WBIT_W  = $clog2(DATA_WIDTH);
    localparam int LINE_W  = DATA_WIDTH << CHUNKS_LOG;
    localparam int SETS    = 1 << SETS_LOG;
    localparam int IDX_LSB = OFF_W + CHUNKS_LOG;
    localparam int TAG_LSB = IDX_LSB + SETS_LOG;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_FILL_REQ  = 3'd3;
    localparam logic [2:0] S_FILL_WAIT = 3'd4;
    localparam logic [2:0] S_RESPOND   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic                  store_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    logic [SETS-1:0]       valid_q;
    logic                  dirty_q [SETS];
    logic [TAG_W-1:0]      tag_arr_q [SETS];
    logic [LINE_W-1:0]     data_q [SETS];

    logic [SETS_LOG-1:0]          idx;
    logic [TAG_W-1:0]             req_tag;
    logic [CHUNKS_LOG+WBIT_W-1:0] word_lsb;
    logic [OFF_W-1:0]             unused_offset;
    logic [LINE_W-1:0]            victim_line, fill_line;
    logic [DATA_WIDTH-1:0]        cur_word, hit_word, fill_word;
    logic                         hit, hit_we, fill_we;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    assign idx           = addr_q[IDX_LSB +: SETS_LOG];
    assign req_tag       = addr_q[TAG_LSB +: TAG_W];
    // Bit position of the selected word inside a line.
    assign word_lsb      = {addr_q[OFF_W +: CHUNKS_LOG], {WBIT_W{1'b0}}};
    assign unused_offset = addr_q[OFF_W-1:0];

    always_comb begin
        victim_line = data_q[idx];
        cur_word    = victim_line[word_lsb +: DATA_WIDTH];
        hit         = valid_q[idx] && (tag_arr_q[idx] == req_tag);
        hit_word    = store_q ? merge_bytes(cur_word, wdata_q, wstrb_q) : cur_word;
        fill_word   = mem_resp_data[word_lsb +: DATA_WIDTH];
        if (store_q) fill_word = merge_bytes(fill_word, wdata_q, wstrb_q);
        fill_line   = mem_resp_data;
        fill_line[word_lsb +: DATA_WIDTH] = fill_word;
    end

    assign hit_we  = (state_q == S_LOOKUP) && hit && store_q;
    assign fill_we = (state_q == S_FILL_WAIT) && mem_resp_valid;

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        case (state_q)
            S_IDLE:      if (cpu_req_valid) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (hit) begin
                    resp_data_d = hit_word;
                    state_d     = S_RESPOND;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_FILL_REQ;
                end
            end
            // The bus buffers the victim line, so the fill follows straight on.
            S_WRITEBACK: if (mem_ready) state_d = S_FILL_REQ;
            S_FILL_REQ:  if (mem_ready) state_d = S_FILL_WAIT;
            S_FILL_WAIT: begin
                if (mem_resp_valid) begin
                    resp_data_d = fill_word;
                    state_d     = S_RESPOND;
                end
            end
            S_RESPOND:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            resp_data_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            if (state_q == S_IDLE && cpu_req_valid) begin
                store_q <= cpu_req_store;
                addr_q  <= cpu_req_addr;
                wdata_q <= cpu_req_wdata;
                wstrb_q <= cpu_req_wstrb;
            end
            if (fill_we) valid_q[idx] <= 1'b1;
        end
    end

    // Tag, dirty and data storage carry no reset; valid_q gates them.
    always_ff @(posedge clk) begin
        if (hit_we) begin
            data_q[idx][word_lsb +: DATA_WIDTH] <= hit_word;
            dirty_q[idx]                        <= 1'b1;
        end
        if (fill_we) begin
            data_q[idx]    <= fill_line;
            tag_arr_q[idx] <= req_tag;
            dirty_q[idx]   <= store_q;
        end
    end

    // Ready is forced low while reset is held, even though the state is IDLE.
    assign cpu_req_ready  = (state_q == S_IDLE) && !reset;
    assign cpu_resp_valid = (state_q == S_RESPOND);
    assign cpu_resp_data  = resp_data_q;
    assign mem_valid      = (state_q == S_WRITEBACK) || (state_q == S_FILL_REQ);
    assign mem_store      = (state_q == S_WRITEBACK);
    assign mem_wdata      = victim_line;
    assign mem_rready     = (state_q == S_FILL_WAIT);

    always_comb begin
        mem_addr = '0;
        if (state_q == S_WRITEBACK)
            mem_addr = {tag_arr_q[idx], idx, {IDX_LSB{1'b0}}};
        else if (state_q == S_FILL_REQ)
            mem_addr = {req_tag, idx, {IDX_LSB{1'b0}}};
    end

endmodule

// File: tb/tb_l1_data_cache.sv
// Bench for l1_data_cache: directed scenarios followed by random traffic.
// The reference is a flat word memory as the core should see it, plus a
// per-set record of which line is resident and whether it is dirty.
module tb_l1_data_cache;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req_valid = 1'b0;
    logic          cpu_req_ready;
    logic          cpu_req_store = 1'b0;
    logic [63:0]   cpu_req_addr = '0;
    logic [63:0]   cpu_req_wdata = '0;
    logic [7:0]    cpu_req_wstrb = '0;
    logic          cpu_resp_valid;
    logic [63:0]   cpu_resp_data;
    logic          mem_valid;
    logic          mem_store;
    logic [63:0]   mem_addr;
    logic [1023:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic [1023:0] mem_resp_data = '0;
    logic          mem_rready;

    l1_data_cache dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_store(cpu_req_store), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
        .mem_valid(mem_valid), .mem_store(mem_store), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_rready(mem_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [63:0] data; int ops; int ops_start; int acc; } exp_t;
    typedef struct { bit st; logic [63:0] addr; logic [63:0] w0; } mlog_t;
    exp_t  exp_q[$];
    mlog_t mem_log[$];
    int    mem_ops = 0;
    int    forced_stall = 0;
    bit    hold_fill = 0;

    // Memory as seen by the bus (bk), by the model (mem_model) and by the core (ref_mem).
    logic [63:0] bk        [logic [63:0]];
    logic [63:0] mem_model [logic [63:0]];
    logic [63:0] ref_mem   [logic [63:0]];
    bit          m_vld [64];
    bit          m_dty [64];
    logic [50:0] m_tag [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEADBEEF, a[31:0]};
    endfunction
    function automatic logic [63:0] bk_rd(input logic [63:0] a);
        return bk.exists(a) ? bk[a] : init_word(a);
    endfunction
    function automatic logic [63:0] mdl_rd(input logic [63:0] a);
        return mem_model.exists(a) ? mem_model[a] : init_word(a);
    endfunction
    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mdl_rd(a);
    endfunction
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] s);
        for (int b = 0; b < 8; b++) if (s[b]) old[8*b +: 8] = nw[8*b +: 8];
        return old;
    endfunction

    task automatic preset(input logic [63:0] a, input logic [63:0] v);
        bk[a] = v; mem_model[a] = v; ref_mem[a] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin m_vld[i] = 0; m_dty[i] = 0; end
        // Dirty lines and the in-flight store are lost: the core view reverts to memory.
        ref_mem = mem_model;
        exp_q.delete();
    endtask

    task automatic do_req(input bit st, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] ws);
        int   g;
        int   ix;
        exp_t e;
        logic [63:0] v;
        g = 0;
        @(negedge clk);
        while (!cpu_req_ready && g < 400) begin @(negedge clk); g++; end
        if (!cpu_req_ready) begin
            chk("req_ready_timeout", cpu_req_ready, 1);
            return;
        end
        ix = int'(a[12:7]);
        if (m_vld[ix] && m_tag[ix] == a[63:13]) begin
            e.ops = 0;
        end else begin
            if (m_vld[ix] && m_dty[ix]) begin
                v = {m_tag[ix], a[12:7], 7'b0};
                for (int w = 0; w < 16; w++) mem_model[v + 64'(8*w)] = ref_rd(v + 64'(8*w));
                e.ops = 2;
            end else begin
                e.ops = 1;
            end
            m_vld[ix] = 1; m_tag[ix] = a[63:13]; m_dty[ix] = 0;
        end
        if (st) begin
            ref_mem[a] = merge(ref_rd(a), wd, ws);
            m_dty[ix] = 1;
        end
        e.data = ref_rd(a);
        e.ops_start = mem_ops;
        e.acc = cyc;
        exp_q.push_back(e);
        cpu_req_valid = 1; cpu_req_store = st; cpu_req_addr = a;
        cpu_req_wdata = wd; cpu_req_wstrb = ws;
        @(negedge clk);
        cpu_req_valid = 0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin @(negedge clk); g++; end
        if (exp_q.size() != 0) begin
            chk("resp_drain", 64'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_resp_valid) begin
                chk("resp_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("resp_data", cpu_resp_data, e.data);
                    chk("mem_op_count", 64'(mem_ops - e.ops_start), 64'(e.ops));
                    if (e.ops == 0) chk("hit_latency", 64'(cyc - e.acc), 2);
                end
            end
        end
    end

    // Bus / memory responder with protocol checks.
    initial begin
        bit            fill_pending, prev_pend, prev_fill_hs, p_store;
        int            fill_lat;
        logic [63:0]   fill_addr, p_addr;
        logic [1023:0] p_wdata;
        mlog_t         m;
        fill_pending = 0; prev_pend = 0; prev_fill_hs = 0; p_store = 0;
        fill_lat = 0; fill_addr = '0; p_addr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_ready = 0; mem_resp_valid = 0;
                fill_pending = 0; prev_pend = 0; prev_fill_hs = 0;
            end else begin
                if (prev_pend) begin
                    chk("mem_valid_held", 64'(mem_valid), 1);
                    chk("mem_addr_stable", mem_addr, p_addr);
                    chk("mem_store_stable", 64'(mem_store), 64'(p_store));
                    chk("mem_wdata_stable", 64'(mem_wdata == p_wdata), 1);
                end
                if (prev_fill_hs) chk("mem_valid_drop", 64'(mem_valid), 0);
                mem_resp_valid = 0;
                if (fill_pending && mem_rready) begin
                    if (fill_lat > 0) fill_lat--;
                    else if (!hold_fill) begin
                        for (int w = 0; w < 16; w++) mem_resp_data[64*w +: 64] = bk_rd(fill_addr + 64'(8*w));
                        mem_resp_valid = 1;
                        fill_pending = 0;
                    end
                end else if (!mem_rready && $urandom_range(0, 7) == 0) begin
                    for (int w = 0; w < 32; w++) mem_resp_data[32*w +: 32] = $urandom;
                    mem_resp_valid = 1;
                end
                if (mem_valid && forced_stall > 0) begin
                    mem_ready = 0;
                    forced_stall--;
                end else begin
                    mem_ready = ($urandom_range(0, 2) != 0);
                end
                prev_pend = mem_valid && !mem_ready;
                prev_fill_hs = mem_valid && mem_ready && !mem_store;
                p_addr = mem_addr; p_store = mem_store; p_wdata = mem_wdata;
                if (mem_valid && mem_ready) begin
                    m.st = mem_store; m.addr = mem_addr; m.w0 = mem_wdata[63:0];
                    mem_log.push_back(m);
                    mem_ops++;
                    if (mem_store) begin
                        for (int w = 0; w < 16; w++) bk[mem_addr + 64'(8*w)] = mem_wdata[64*w +: 64];
                    end else begin
                        fill_pending = 1; fill_addr = mem_addr; fill_lat = $urandom_range(0, 3);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int t, ix, w;
        logic [63:0] a;
        model_reset();
        @(negedge clk);
        chk("rst_req_ready", 64'(cpu_req_ready), 0);
        chk("rst_resp_valid", 64'(cpu_resp_valid), 0);
        chk("rst_mem_valid", 64'(mem_valid), 0);
        chk("rst_mem_store", 64'(mem_store), 0);
        chk("rst_mem_rready", 64'(mem_rready), 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 0;
        @(negedge clk);
        chk("post_rst_ready", 64'(cpu_req_ready), 1);

        // Cold load: fill only, data from the fill.
        preset(64'h1000, 64'hAA);
        mem_log.delete();
        do_req(0, 64'h1000, '0, '0);
        drain();
        chk("cold_log_size", 64'(mem_log.size()), 1);
        if (mem_log.size() > 0) begin
            chk("cold_is_fill", 64'(mem_log[0].st), 0);
            chk("cold_fill_addr", mem_log[0].addr, 64'h1000);
        end

        // Hit in the same line, then a partial store.
        do_req(0, 64'h1008, '0, '0);
        drain();
        do_req(1, 64'h1000, 64'h1122334455667788, 8'h0F);
        drain();

        // Conflict miss on a dirty line with the writeback held off for 5 cycles.
        mem_log.delete();
        forced_stall = 5;
        do_req(0, 64'h3000, '0, '0);
        drain();
        chk("evict_log_size", 64'(mem_log.size()), 2);
        if (mem_log.size() == 2) begin
            chk("wb_is_store", 64'(mem_log[0].st), 1);
            chk("wb_addr", mem_log[0].addr, 64'h1000);
            chk("wb_word0", mem_log[0].w0, 64'h0000000055667788);
            chk("refill_is_fill", 64'(mem_log[1].st), 0);
            chk("refill_addr", mem_log[1].addr, 64'h3000);
        end

        // Reset while waiting for a fill: request dropped, next access misses again.
        hold_fill = 1;
        do_req(0, 64'h5000, '0, '0);
        g = 0;
        while (!mem_rready && g < 200) begin @(negedge clk); g++; end
        chk("reached_fill_wait", 64'(mem_rready), 1);
        @(posedge clk);
        #1 reset = 1;
        #1;
        chk("async_rst_rready", 64'(mem_rready), 0);
        chk("async_rst_mem_valid", 64'(mem_valid), 0);
        chk("async_rst_req_ready", 64'(cpu_req_ready), 0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 0;
        hold_fill = 0;
        do_req(0, 64'h5000, '0, '0);
        drain();
        do_req(0, 64'h1000, '0, '0);
        drain();

        // Random traffic over a few sets and tags to force conflicts and evictions.
        for (int n = 0; n < 300; n++) begin
            t  = $urandom_range(0, 3);
            ix = $urandom_range(30, 33);
            w  = $urandom_range(0, 15);
            a  = (64'(t) << 13) | (64'(ix) << 7) | (64'(w) << 3);
            if ($urandom_range(0, 1) == 1)
                do_req(1, a, {$urandom, $urandom}, 8'($urandom));
            else
                do_req(0, a, '0, '0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
